// File: rtl/score_keeper.sv
// score_keeper: game-state and score generator for the score overlay.
// Counts goal/snitch points with saturation and runs a countdown game timer.
// It sequences IDLE -> PLAYING -> OVER. All outputs are registered.
// Optional feature macro: SCORE_KEEPER_HIGH_SCORE_EN. When it is defined,
// the block keeps the best final score seen since reset.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | after reset, waiting for a start edge
//   PLAYING | game running: events add points, sec_tick counts down
//   OVER    | game finished, score/time_left frozen until next start edge
module score_keeper #(
  parameter int GOAL_POINTS   = 10,
  parameter int SNITCH_POINTS = 150,
  parameter int GAME_SECONDS  = 120,
  parameter int SCORE_MAX     = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        goal,
  input  logic        snitch,
  input  logic        sec_tick,
  output logic [13:0] score,
  output logic        playing_reg,
  output logic        game_over,
  output logic [7:0]  time_left,
  output logic [13:0] high_score
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_OVER    = 2'd2
  } state_e;

  state_e      state_q;
  logic        start_q;
  logic        start_rise;
  logic [13:0] score_q;
  logic [13:0] score_d;
  logic [7:0]  time_q;
  logic [7:0]  time_d;
  logic        playing_q;
  logic        over_q;
  logic [14:0] inc;
  logic [14:0] sum;
  logic        end_game;

  // start_q resets high so a button held through reset release is not an edge
  assign start_rise = start & ~start_q;

  // Saturating score update and countdown; a snitch catch freezes the timer
  always_comb begin
    inc = '0;
    if (goal)   inc = inc + 15'(GOAL_POINTS);
    if (snitch) inc = inc + 15'(SNITCH_POINTS);
    sum      = {1'b0, score_q} + inc;
    score_d  = (sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : sum[13:0];
    end_game = snitch | (sec_tick & (time_q == 8'd1));
    time_d   = time_q;
    if (sec_tick && !snitch) time_d = time_q - 8'd1;
  end

  // Game FSM with registered score, timer and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b1;
      score_q   <= '0;
      time_q    <= 8'(GAME_SECONDS);
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        S_PLAYING: begin
          score_q <= score_d;
          time_q  <= time_d;
          if (end_game) begin
            state_q   <= S_OVER;
            playing_q <= 1'b0;
            over_q    <= 1'b1;
          end
        end
        default: begin
          if (start_rise) begin
            state_q   <= S_PLAYING;
            score_q   <= '0;
            time_q    <= 8'(GAME_SECONDS);
            playing_q <= 1'b1;
            over_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign score       = score_q;
  assign time_left   = time_q;
  assign playing_reg = playing_q;
  assign game_over   = over_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [13:0] high_q;

  // Capture the final score on the cycle the game ends, if it is a new best
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_q <= '0;
    end else if (state_q == S_PLAYING && end_game && score_d > high_q) begin
      high_q <= score_d;
    end
  end

  assign high_score = high_q;
`else
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: an integer game model is compared
// against the DUT on every falling edge, and directed literal checks pin it.
module tb_score_keeper;

  logic        clk;
  logic        reset;
  logic        start;
  logic        goal;
  logic        snitch;
  logic        sec_tick;
  logic [13:0] score;
  logic        playing_reg;
  logic        game_over;
  logic [7:0]  time_left;
  logic [13:0] high_score;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  score_keeper dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .goal       (goal),
    .snitch     (snitch),
    .sec_tick   (sec_tick),
    .score      (score),
    .playing_reg(playing_reg),
    .game_over  (game_over),
    .time_left  (time_left),
    .high_score (high_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: 0 = idle, 1 = playing, 2 = over
  int m_state, m_score, m_time, m_high, m_inc, m_sum;
  bit m_prev, m_rise, m_fin;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_score = 0; m_time = 120; m_high = 0; m_prev = 1;
    end else begin
      m_rise = start && !m_prev;
      m_prev = start;
      if (m_state == 1) begin
        m_inc   = (goal ? 10 : 0) + (snitch ? 150 : 0);
        m_sum   = m_score + m_inc;
        m_score = (m_sum > 999) ? 999 : m_sum;
        m_fin   = snitch || (sec_tick && m_time == 1);
        if (sec_tick && !snitch) m_time = m_time - 1;
        if (m_fin) begin
          m_state = 2;
          if (HS_EN && m_score > m_high) m_high = m_score;
        end
      end else if (m_rise) begin
        m_state = 1; m_score = 0; m_time = 120;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_score",   int'(score),       m_score);
      chk("model_time",    int'(time_left),   m_time);
      chk("model_playing", int'(playing_reg), (m_state == 1) ? 1 : 0);
      chk("model_over",    int'(game_over),   (m_state == 2) ? 1 : 0);
      chk("model_high",    int'(high_score),  m_high);
      if (playing_reg && game_over) chk("flags_exclusive", 1, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit g, input bit s, input bit t);
    goal = g; snitch = s; sec_tick = t;
    step();
    goal = 0; snitch = 0; sec_tick = 0;
  endtask

  task automatic new_game();
    start = 0;
    step();
    start = 1;
    step();
    chk("new_game_playing", int'(playing_reg), 1);
    chk("new_game_score",   int'(score),       0);
  endtask

  initial begin
    clk = 0; reset = 1; start = 1; goal = 0; snitch = 0; sec_tick = 0;
    #2 reset = 0;
    #1 chk_en = 1;
    #19 reset = 1;
    step();
    chk("reset_score",   int'(score),       0);
    chk("reset_time",    int'(time_left),   120);
    chk("reset_over",    int'(game_over),   0);
    repeat (3) step();
    chk("idle_held_start", int'(playing_reg), 0);
    pulse(1, 0, 0);
    chk("idle_goal_ignored", int'(score), 0);

    start = 0; step();
    start = 1; step();
    chk("start_playing", int'(playing_reg), 1);
    chk("start_time",    int'(time_left),   120);
    chk("start_score",   int'(score),       0);

    repeat (3) begin pulse(1, 0, 0); step(); end
    chk("three_goals", int'(score), 30);
    start = 0; step(); start = 1; step();
    chk("restart_ignored_score",   int'(score),       30);
    chk("restart_ignored_playing", int'(playing_reg), 1);
    pulse(0, 0, 1); pulse(0, 0, 1);
    chk("two_ticks", int'(time_left), 118);
    pulse(0, 1, 1);
    chk("snitch_score",   int'(score),       180);
    chk("snitch_over",    int'(game_over),   1);
    chk("snitch_playing", int'(playing_reg), 0);
    chk("snitch_freeze",  int'(time_left),   118);
    pulse(1, 0, 0); pulse(0, 0, 1);
    chk("over_hold_score", int'(score),     180);
    chk("over_hold_time",  int'(time_left), 118);

    new_game();
    pulse(1, 1, 0);
    chk("both_score", int'(score),     160);
    chk("both_over",  int'(game_over), 1);

    new_game();
    repeat (90) pulse(1, 0, 0);
    chk("score_900", int'(score), 900);
    pulse(0, 1, 0);
    chk("saturate_999", int'(score), 999);

    new_game();
    repeat (119) pulse(0, 0, 1);
    chk("time_one",      int'(time_left),   1);
    chk("time_one_play", int'(playing_reg), 1);
    pulse(1, 0, 1);
    chk("expire_score",   int'(score),       10);
    chk("expire_time",    int'(time_left),   0);
    chk("expire_over",    int'(game_over),   1);
    chk("expire_playing", int'(playing_reg), 0);

    reset = 0; #2 reset = 1;
    step();
    new_game();
    pulse(0, 1, 0);
    chk("game1_score", int'(score), 150);
    chk("game1_high",  int'(high_score), HS_EN ? 150 : 0);
    new_game();
    repeat (4) pulse(1, 0, 0);
    repeat (120) pulse(0, 0, 1);
    chk("game2_score", int'(score),     40);
    chk("game2_over",  int'(game_over), 1);
    chk("game2_high",  int'(high_score), HS_EN ? 150 : 0);

    new_game();
    repeat (7) pulse(1, 0, 0);
    chk("pre_reset_score", int'(score), 70);
    #2 reset = 0;
    #1;
    chk("async_score",   int'(score),       0);
    chk("async_playing", int'(playing_reg), 0);
    chk("async_time",    int'(time_left),   120);
    chk("async_high",    int'(high_score),  0);
    #1 reset = 1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-state and score generator that produces the `score` and `playing_reg` values consumed by the on-screen score overlay. It accumulates points from one-cycle game events (goal, snitch catch), runs a countdown game timer, and sequences IDLE → PLAYING → OVER. All outputs are registered and feed the display path and top-level colour mux directly.

## Interface
- `GOAL_POINTS`, 10: points added per `goal` pulse.
- `SNITCH_POINTS`, 150: points added per `snitch` pulse; also ends the game.
- `GAME_SECONDS`, 120: initial countdown value (1..255).
- `SCORE_MAX`, 999: saturation ceiling; the display is three BCD digits.

- `clk`  in  1  system clock (pixel clock domain).
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  debounced start button, level-sensitive, rising edge used.
- `goal`  in  1  one-cycle pulse: quaffle scored.
- `snitch`  in  1  one-cycle pulse: snitch caught.
- `sec_tick`  in  1  one-cycle pulse, once per second.
- `score`  out  14  current score, binary, 0..SCORE_MAX.
- `playing_reg`  out  1  high while in PLAYING.
- `game_over`  out  1  high while in OVER.
- `time_left`  out  8  seconds remaining.
- `high_score`  out  14  best score since reset (see Configuration).

## Operation
- Start edge: `start_q` register; `start_rise = start & ~start_q`. `start_q` resets to 1, so a button held through reset release does not start a game.
- FSM states:
  - IDLE: reset state.
  - PLAYING.
  - OVER.
- IDLE/OVER → PLAYING on `start_rise`:
  - `score` ← 0.
  - `time_left` ← GAME_SECONDS.
- PLAYING, per cycle:
  - Increment `inc = (goal ? GOAL_POINTS : 0) + (snitch ? SNITCH_POINTS : 0)`.
  - `score ← min(score + inc, SCORE_MAX)`.
  - Compute the sum at 15 bits before saturating; no wrap.
- PLAYING, `sec_tick`: `time_left` decrements. Transition to OVER when either:
  - `sec_tick` arrives with `time_left == 1`; `time_left` becomes 0.
  - `snitch` is asserted; `time_left` is frozen.
- `goal` and `snitch` in the same cycle: both are added (160 with defaults), then OVER.
- Expiring `sec_tick` coincident with `goal`: the goal counts, then OVER.
- `goal`, `snitch` and `sec_tick` are ignored in IDLE and OVER.
- OVER holds `score` and `time_left` unchanged.
- `start_rise` in PLAYING is ignored.

## Timing
- Reset values:
  - FSM = IDLE.
  - `score` = 0.
  - `playing_reg` = 0.
  - `game_over` = 0.
  - `time_left` = GAME_SECONDS.
  - `high_score` = 0.
  - `start_q` = 1.
- Event pulse sampled at edge N → updated `score` visible after edge N+1. Latency is 1 cycle, with no combinational input-to-output path.
- `start` rising at edge N (`start_q` still 0) → `playing_reg` = 1, `score` = 0 and `time_left` = GAME_SECONDS after edge N+1.
- The end condition at edge N produces all of the following together after edge N+1:
  - `playing_reg` falls.
  - `game_over` rises.
  - Final `score` is valid.
- `playing_reg` and `game_over` are never both 1.
- Reset assertion mid-game returns all outputs to reset values immediately (asynchronous). This includes `high_score`.
- Event inputs must be single-cycle; a held pulse adds points every cycle.

## Configuration
- `SCORE_KEEPER_HIGH_SCORE_EN` defined:
  - On the PLAYING → OVER transition, if the final score exceeds `high_score`, `high_score` takes the final score.
  - The new value is visible on the same cycle `game_over` rises.
  - The value survives new games; only reset clears it.
- Not defined: `high_score` is constant 0 and no register is inferred.

## Test plan
- Reset with `start` held high, then release reset → remains IDLE, `playing_reg` = 0. Drop `start`, raise it → `playing_reg` = 1 one cycle later, `time_left` = 120, `score` = 0.
- PLAYING, 3 `goal` pulses → `score` = 30. Then one `snitch` → `score` = 180, `game_over` = 1, `playing_reg` = 0. A further `goal` leaves `score` at 180.
- PLAYING, `goal` and `snitch` in the same cycle from `score` = 0 → `score` = 160, OVER.
- PLAYING, `score` = 900, `snitch` → `score` = 999 (saturated). Run 120 `sec_tick` pulses in a new game with a goal on the last tick → `score` = 10, `time_left` = 0, OVER.
- With macro: game 1 ends at 150, game 2 ends at 40 → `high_score` = 150 after both. Without macro: `high_score` = 0 throughout.
- Reset asserted mid-game at `score` = 70 → `score` = 0 and `playing_reg` = 0 immediately, before the next clock edge.
